// File: rtl/pipe_latch_elastic_pkg.sv
// Shared constants for the elastic inter-stage pipeline latches.
// Stage structs are flattened to WIDTH-bit vectors by the caller.
package pipe_latch_elastic_pkg;

  localparam int unsigned PIPE_DEPTH_DEFAULT = 2;
  localparam int unsigned PIPE_CNTW          = 32;

  // Pointer width for a given skid depth; never narrower than one bit.
  function automatic int unsigned pipe_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_latch_elastic_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module pipe_sat_counter
  import pipe_latch_elastic_pkg::*;
#(
  parameter int unsigned W = PIPE_CNTW
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_latch_elastic.sv
// Elastic pipeline latch: DEPTH-entry circular skid buffer with valid/ready on both
// sides, synchronous flush, and saturating stall/bubble counters.
module pipe_latch_elastic
  import pipe_latch_elastic_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = PIPE_DEPTH_DEFAULT,
  parameter int unsigned CNTW  = PIPE_CNTW
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     flush,
  input  logic                     clr_cnt,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNTW-1:0]          stall_cnt,
  output logic [CNTW-1:0]          bubble_cnt
);

  localparam int unsigned AW = pipe_ptr_w(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             push, pop;

  // Ready depends only on local occupancy, so no combinational path from out_ready.
  assign in_ready  = (occ_q < OW'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign out_data  = out_valid ? mem_q[head_q] : '0;
  assign occupancy = occ_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Storage is not reset or cleared on flush; the empty rule masks stale words.
  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      mem_q[tail_q] <= in_data;
    end
  end

  // Counters look at pre-flush out_valid and ignore flush entirely.
  pipe_sat_counter #(
    .W (CNTW)
  ) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (clr_cnt),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(
    .W (CNTW)
  ) u_bubble_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (clr_cnt),
    .inc   (!out_valid && out_ready),
    .count (bubble_cnt)
  );

endmodule
